// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for the hazard/forwarding controller.
// The master modport is the pipeline; the slave modport is hazard_unit.
interface hazard_unit_if #(
    parameter int XLEN  = 32,
    parameter int NRD   = 2,
    parameter int CNT_W = 32
);
    logic [NRD-1:0]      rf_re_id;
    logic [5*NRD-1:0]    rf_ra_id;
    logic [5*NRD-1:0]    rf_ra_ex;
    logic                rf_we_ex;
    logic                is_load_ex;
    logic [4:0]          rf_wa_ex;
    logic                mdu_start_ex;
    logic                br_taken_ex;
    logic                rf_we_mem;
    logic                rf_we_wb;
    logic [4:0]          rf_wa_mem;
    logic [4:0]          rf_wa_wb;
    logic [XLEN-1:0]     rf_wd_mem;
    logic [XLEN-1:0]     rf_wd_wb;

    logic [NRD-1:0]      fwd_en;
    logic [XLEN*NRD-1:0] fwd_data;
    logic                stall_if;
    logic                stall_id;
    logic                stall_ex;
    logic                flush_id;
    logic                flush_ex;
    logic                flush_mem;
    logic                mdu_busy;
    logic                mdu_done;
    logic [CNT_W-1:0]    lu_stall_cnt;
    logic [CNT_W-1:0]    mdu_stall_cnt;

    modport master (
        output rf_re_id, rf_ra_id, rf_ra_ex, rf_we_ex, is_load_ex, rf_wa_ex,
               mdu_start_ex, br_taken_ex, rf_we_mem, rf_we_wb, rf_wa_mem,
               rf_wa_wb, rf_wd_mem, rf_wd_wb,
        input  fwd_en, fwd_data, stall_if, stall_id, stall_ex, flush_id,
               flush_ex, flush_mem, mdu_busy, mdu_done, lu_stall_cnt,
               mdu_stall_cnt
    );

    modport slave (
        input  rf_re_id, rf_ra_id, rf_ra_ex, rf_we_ex, is_load_ex, rf_wa_ex,
               mdu_start_ex, br_taken_ex, rf_we_mem, rf_we_wb, rf_wa_mem,
               rf_wa_wb, rf_wd_mem, rf_wd_wb,
        output fwd_en, fwd_data, stall_if, stall_id, stall_ex, flush_id,
               flush_ex, flush_mem, mdu_busy, mdu_done, lu_stall_cnt,
               mdu_stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, load-use detection, MDU hold sequencing and branch-flush
// arbitration for the 5-stage pipeline, with saturating stall counters.
//
// state | meaning
// IDLE  | no MDU op occupying EX beyond its issue cycle
// BUSY  | MDU op holding EX; cnt counts remaining stall cycles
module hazard_unit #(
    parameter int XLEN    = 32,
    parameter int NRD     = 2,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         rst,
    hazard_unit_if.slave hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit             MULTI    = (MDU_LAT > 1);
    localparam logic [3:0]     CNT_INIT = MULTI ? 4'(MDU_LAT - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state;
    logic [3:0]       cnt;
    logic             busy;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mdu_cnt;

    logic [NRD-1:0]      fwd_en;
    logic [XLEN*NRD-1:0] fwd_data;
    logic                lu;
    logic                mstall;
    logic                done;
    logic                lu_fire;
    logic                s_if, s_id, s_ex, f_id, f_ex, f_mem;

    always_comb begin
        fwd_en   = '0;
        fwd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (hz.rf_we_mem && hz.rf_wa_mem != 5'd0 &&
                hz.rf_wa_mem == hz.rf_ra_ex[5*i +: 5]) begin
                fwd_en[i]                 = 1'b1;
                fwd_data[XLEN*i +: XLEN]  = hz.rf_wd_mem;
            end else if (hz.rf_we_wb && hz.rf_wa_wb != 5'd0 &&
                         hz.rf_wa_wb == hz.rf_ra_ex[5*i +: 5]) begin
                fwd_en[i]                 = 1'b1;
                fwd_data[XLEN*i +: XLEN]  = hz.rf_wd_wb;
            end
        end
    end

    always_comb begin
        lu = 1'b0;
        if (hz.is_load_ex && hz.rf_we_ex && hz.rf_wa_ex != 5'd0) begin
            for (int i = 0; i < NRD; i++) begin
                if (hz.rf_re_id[i] && hz.rf_ra_id[5*i +: 5] == hz.rf_wa_ex)
                    lu = 1'b1;
            end
        end
    end

    // The final BUSY cycle belongs to the same MDU instruction, so its start is ignored.
    always_comb begin
        mstall = 1'b0;
        done   = 1'b0;
        if (state == IDLE) begin
            mstall = hz.mdu_start_ex && MULTI;
            done   = hz.mdu_start_ex && !MULTI;
        end else begin
            mstall = (cnt != 4'd0);
            done   = (cnt == 4'd0);
        end
        if (rst) begin
            mstall = 1'b0;
            done   = 1'b0;
        end
    end

    always_comb begin
        s_if    = 1'b0;
        s_id    = 1'b0;
        s_ex    = 1'b0;
        f_id    = 1'b0;
        f_ex    = 1'b0;
        f_mem   = 1'b0;
        lu_fire = 1'b0;
        if (!rst) begin
            if (mstall) begin
                s_if  = 1'b1;
                s_id  = 1'b1;
                s_ex  = 1'b1;
                f_mem = 1'b1;
            end else if (hz.br_taken_ex) begin
                f_id = 1'b1;
                f_ex = 1'b1;
            end else if (lu) begin
                s_if    = 1'b1;
                s_id    = 1'b1;
                f_ex    = 1'b1;
                lu_fire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.mdu_start_ex && MULTI) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt  <= '0;
            mdu_cnt <= '0;
        end else begin
            if (lu_fire && lu_cnt != '1)
                lu_cnt <= lu_cnt + CNT_ONE;
            if (mstall && mdu_cnt != '1)
                mdu_cnt <= mdu_cnt + CNT_ONE;
        end
    end

    assign hz.fwd_en        = fwd_en;
    assign hz.fwd_data      = fwd_data;
    assign hz.stall_if      = s_if;
    assign hz.stall_id      = s_id;
    assign hz.stall_ex      = s_ex;
    assign hz.flush_id      = f_id;
    assign hz.flush_ex      = f_ex;
    assign hz.flush_mem     = f_mem;
    assign hz.mdu_busy      = busy;
    assign hz.mdu_done      = done;
    assign hz.lu_stall_cnt  = lu_cnt;
    assign hz.mdu_stall_cnt = mdu_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations each cycle,
// a negedge monitor pops and compares against one of two DUT configurations.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut 0: MDU_LAT=4, CNT_W=32; dut 1: MDU_LAT=1, CNT_W=3
    hazard_unit_if #(.XLEN(32), .NRD(2), .CNT_W(32)) ifa ();
    hazard_unit_if #(.XLEN(32), .NRD(2), .CNT_W(3))  ifb ();

    hazard_unit #(.XLEN(32), .NRD(2), .MDU_LAT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa.slave));
    hazard_unit #(.XLEN(32), .NRD(2), .MDU_LAT(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb.slave));

    typedef struct {
        string       name;
        int          dut;
        logic [5:0]  ctl;    // {stall_if,stall_id,stall_ex,flush_id,flush_ex,flush_mem}
        bit          c_mdu;
        logic [1:0]  mdu;    // {busy,done}
        bit          c_fwd;
        logic [1:0]  fen;
        logic [63:0] fdat;
        bit          c_cnt;
        logic [31:0] luc;
        logic [31:0] mduc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cycle(string name, int dut, logic [5:0] ctl, logic [1:0] mdu,
                             int luc, int mduc);
        exp_t e;
        e.name = name; e.dut = dut; e.ctl = ctl;
        e.c_mdu = 1'b1; e.mdu = mdu;
        e.c_fwd = 1'b0; e.fen = '0; e.fdat = '0;
        e.c_cnt = 1'b1; e.luc = 32'(luc); e.mduc = 32'(mduc);
        q.push_back(e);
    endtask

    task automatic exp_fwd(string name, logic [1:0] fen, logic [63:0] fdat);
        exp_t e;
        e.name = name; e.dut = 0; e.ctl = 6'b0;
        e.c_mdu = 1'b0; e.mdu = '0;
        e.c_fwd = 1'b1; e.fen = fen; e.fdat = fdat;
        e.c_cnt = 1'b0; e.luc = '0; e.mduc = '0;
        q.push_back(e);
    endtask

    task automatic clear_inputs();
        ifa.rf_re_id = '0; ifa.rf_ra_id = '0; ifa.rf_ra_ex = '0;
        ifa.rf_we_ex = 0; ifa.is_load_ex = 0; ifa.rf_wa_ex = '0;
        ifa.mdu_start_ex = 0; ifa.br_taken_ex = 0;
        ifa.rf_we_mem = 0; ifa.rf_we_wb = 0; ifa.rf_wa_mem = '0; ifa.rf_wa_wb = '0;
        ifa.rf_wd_mem = '0; ifa.rf_wd_wb = '0;
        ifb.rf_re_id = '0; ifb.rf_ra_id = '0; ifb.rf_ra_ex = '0;
        ifb.rf_we_ex = 0; ifb.is_load_ex = 0; ifb.rf_wa_ex = '0;
        ifb.mdu_start_ex = 0; ifb.br_taken_ex = 0;
        ifb.rf_we_mem = 0; ifb.rf_we_wb = 0; ifb.rf_wa_mem = '0; ifb.rf_wa_wb = '0;
        ifb.rf_wd_mem = '0; ifb.rf_wd_wb = '0;
    endtask

    task automatic lu_a(logic [1:0] re, logic [4:0] wa);
        ifa.is_load_ex = 1; ifa.rf_we_ex = 1; ifa.rf_wa_ex = wa;
        ifa.rf_re_id = re; ifa.rf_ra_id = {5'd3, 5'd0};
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [5:0]  ctl;
        logic [1:0]  mdu, fen;
        logic [63:0] fdat;
        logic [31:0] luc, mduc;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
                ctl  = {ifa.stall_if, ifa.stall_id, ifa.stall_ex,
                        ifa.flush_id, ifa.flush_ex, ifa.flush_mem};
                mdu  = {ifa.mdu_busy, ifa.mdu_done};
                fen  = ifa.fwd_en; fdat = ifa.fwd_data;
                luc  = ifa.lu_stall_cnt; mduc = ifa.mdu_stall_cnt;
            end else begin
                ctl  = {ifb.stall_if, ifb.stall_id, ifb.stall_ex,
                        ifb.flush_id, ifb.flush_ex, ifb.flush_mem};
                mdu  = {ifb.mdu_busy, ifb.mdu_done};
                fen  = ifb.fwd_en; fdat = ifb.fwd_data;
                luc  = {29'd0, ifb.lu_stall_cnt}; mduc = {29'd0, ifb.mdu_stall_cnt};
            end
            checks++;
            if (ctl !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b want %b", e.name, ctl, e.ctl);
            end
            if (e.c_mdu) begin
                checks++;
                if (mdu !== e.mdu) begin
                    errors++;
                    $display("FAIL %s busy_done: got %b want %b", e.name, mdu, e.mdu);
                end
            end
            if (e.c_fwd) begin
                checks++;
                if (fen !== e.fen || fdat !== e.fdat) begin
                    errors++;
                    $display("FAIL %s fwd: got en=%b data=%h want en=%b data=%h",
                             e.name, fen, fdat, e.fen, e.fdat);
                end
            end
            if (e.c_cnt) begin
                checks++;
                if (luc !== e.luc || mduc !== e.mduc) begin
                    errors++;
                    $display("FAIL %s counters: got lu=%0d mdu=%0d want lu=%0d mdu=%0d",
                             e.name, luc, mduc, e.luc, e.mduc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick(); exp_cycle("reset_a", 0, 6'b0, 2'b00, 0, 0);
        tick(); exp_cycle("reset_b", 1, 6'b0, 2'b00, 0, 0);
        tick(); rst = 1'b0;

        // forwarding
        ifa.rf_we_mem = 1; ifa.rf_wa_mem = 5'd5; ifa.rf_wd_mem = 32'h11;
        ifa.rf_we_wb  = 1; ifa.rf_wa_wb  = 5'd5; ifa.rf_wd_wb  = 32'h22;
        ifa.rf_ra_ex = {5'd5, 5'd5};
        exp_fwd("fwd_mem_prio", 2'b11, {32'h11, 32'h11});
        tick(); ifa.rf_wa_mem = 5'd0;
        exp_fwd("fwd_wb", 2'b11, {32'h22, 32'h22});
        tick(); ifa.rf_wa_wb = 5'd0;
        exp_fwd("fwd_x0", 2'b00, 64'h0);
        tick();
        ifa.rf_ra_ex = {5'd9, 5'd7};
        ifa.rf_wa_mem = 5'd9; ifa.rf_wd_mem = 32'hAA;
        ifa.rf_wa_wb  = 5'd7; ifa.rf_wd_wb  = 32'hBB;
        exp_fwd("fwd_mixed", 2'b11, {32'hAA, 32'hBB});
        tick(); ifa.rf_we_mem = 0;
        exp_fwd("fwd_mem_we0", 2'b01, {32'h0, 32'hBB});
        tick(); clear_inputs();

        // load-use
        lu_a(2'b10, 5'd3);
        exp_cycle("lu_stall", 0, 6'b110010, 2'b00, 0, 0);
        tick(); clear_inputs();
        exp_cycle("lu_release", 0, 6'b0, 2'b00, 1, 0);
        tick(); lu_a(2'b01, 5'd3);
        exp_cycle("lu_re_off", 0, 6'b0, 2'b00, 1, 0);
        tick(); lu_a(2'b10, 5'd0);
        exp_cycle("lu_wa_x0", 0, 6'b0, 2'b00, 1, 0);
        tick(); lu_a(2'b10, 5'd3); ifa.br_taken_ex = 1;
        exp_cycle("br_vs_lu", 0, 6'b000110, 2'b00, 1, 0);
        tick(); clear_inputs();
        exp_cycle("br_after", 0, 6'b0, 2'b00, 1, 0);

        // MDU, MDU_LAT=4
        tick(); ifa.mdu_start_ex = 1;
        exp_cycle("mdu_T0", 0, 6'b111001, 2'b00, 1, 0);
        tick(); lu_a(2'b10, 5'd3);
        exp_cycle("mdu_T1_lu", 0, 6'b111001, 2'b10, 1, 1);
        tick(); ifa.is_load_ex = 0; ifa.br_taken_ex = 1;
        exp_cycle("mdu_T2_br", 0, 6'b111001, 2'b10, 1, 2);
        tick(); ifa.br_taken_ex = 0; ifa.rf_re_id = '0; ifa.rf_we_ex = 0;
        exp_cycle("mdu_T3_done", 0, 6'b0, 2'b11, 1, 3);
        tick(); clear_inputs();
        exp_cycle("mdu_T4", 0, 6'b0, 2'b00, 1, 3);

        // reset while BUSY
        tick(); ifa.mdu_start_ex = 1;
        exp_cycle("rstmdu_T0", 0, 6'b111001, 2'b00, 1, 3);
        tick(); rst = 1'b1;
        exp_cycle("rstmdu_T1", 0, 6'b0, 2'b10, 1, 4);
        tick(); rst = 1'b0; ifa.mdu_start_ex = 0;
        exp_cycle("rstmdu_T2", 0, 6'b0, 2'b00, 0, 0);

        // MDU_LAT=1
        tick(); ifb.mdu_start_ex = 1;
        exp_cycle("mdu1_T0", 1, 6'b0, 2'b01, 0, 0);
        tick(); ifb.mdu_start_ex = 0;
        exp_cycle("mdu1_T1", 1, 6'b0, 2'b00, 0, 0);

        // saturation, CNT_W=3
        for (int k = 0; k < 9; k++) begin
            tick();
            ifb.is_load_ex = 1; ifb.rf_we_ex = 1; ifb.rf_wa_ex = 5'd3;
            ifb.rf_re_id = 2'b10; ifb.rf_ra_id = {5'd3, 5'd0};
            exp_cycle("sat_lu", 1, 6'b110010, 2'b00, (k < 7) ? k : 7, 0);
        end
        tick(); clear_inputs();
        exp_cycle("sat_hold", 1, 6'b0, 2'b00, 7, 0);

        tick(); tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
